// File: rtl/mem_stream_reader.sv
// Sequential reader for the dual-port spectrum buffer. It issues R0 reads and streams the
// returned words out over ready/valid, using a 2-entry skid FIFO to absorb backpressure.
module mem_stream_reader #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [ADDR_W:0] ONE = 1;

   state_t                   state, state_nxt;
   logic [ADDR_W-1:0]        base_q, addr_q, rd_addr;
   logic [ADDR_W:0]          len_q, rd_cnt;
   logic                     inflight, inflight_last, done_q;
   logic [1:0][DATA_W-1:0]   fifo_data;
   logic [1:0]               fifo_last;
   logic                     wr_ptr, rd_ptr;
   logic [1:0]               fifo_count;
   logic [2:0]               occ;
   logic                     accept, pop, issue, issue_last;

   assign accept     = (state == IDLE) && start && (length != '0);
   assign out_valid  = (fifo_count != 2'd0);
   assign pop        = out_valid && out_ready;
   assign rd_addr    = base_q + rd_cnt[ADDR_W-1:0];
   // Slots committed once this edge settles; counting the pop this cycle keeps
   // one beat per cycle under full readiness without ever overfilling the FIFO.
   assign occ        = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
   assign issue      = (state == RUN) && (occ < 3'd2);
   assign issue_last = issue && (rd_cnt == len_q - ONE);

   assign mem_en   = issue;
   assign mem_addr = issue ? rd_addr : addr_q;
   assign out_data = fifo_data[rd_ptr];
   assign out_last = out_valid && fifo_last[rd_ptr];
   assign busy     = (state != IDLE);
   assign done     = done_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (issue_last) state_nxt = DRAIN;
         DRAIN:   if (pop && out_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         base_q        <= '0;
         len_q         <= '0;
         rd_cnt        <= '0;
         addr_q        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state         <= state_nxt;
         inflight      <= issue;
         inflight_last <= issue_last;
         done_q        <= ((state == IDLE) && start && (length == '0)) || (pop && out_last);
         if (accept) begin
            base_q <= base_addr;
            len_q  <= length;
            rd_cnt <= '0;
         end else if (issue) begin
            rd_cnt <= rd_cnt + ONE;
            addr_q <= rd_addr;
         end
      end
   end

   // Return data lands one cycle after the read; inflight marks that cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fifo_data  <= '0;
         fifo_last  <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_count <= 2'd0;
      end else begin
         if (inflight) begin
            fifo_data[wr_ptr] <= mem_data;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a behavioural 512x32 buffer (word = addr*3).
module tb_mem_stream_reader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  base_addr = '0;
   logic [9:0]  length = '0;
   logic        busy, done, mem_en, out_valid, out_last;
   logic        out_ready = 1'b0;
   logic [8:0]  mem_addr;
   logic [31:0] mem_data, out_data;

   logic [31:0] mem [512];

   int errors = 0;
   int checks = 0;

   logic [31:0] beat_d[$];
   bit          beat_l[$];
   int          addr_log[$];
   int          hs_cyc[$];
   int          viol, done_cyc, en_cnt, busy_drop;
   bit          busy_seen, valid_seen;

   mem_stream_reader #(.ADDR_W(9), .DATA_W(32)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (mem_en) mem_data <= mem[mem_addr];

   // Stimulus/observation driver: pulses start, drives out_ready each cycle and logs
   // issued addresses, handshaken beats and protocol violations until done or bound.
   // rmode 0: ready held high, 1: random ready, 2: random ready + second start at cycle 3.
   task automatic do_xfer(input int base, input int len, input int rmode, input int bound);
      logic pv, pr, pl;
      logic [31:0] pd;
      beat_d.delete(); beat_l.delete(); addr_log.delete(); hs_cyc.delete();
      viol = 0; done_cyc = -1; en_cnt = 0; busy_drop = 0; busy_seen = 0; valid_seen = 0;
      pv = 0; pr = 0; pl = 0; pd = '0;
      for (int k = 0; k <= bound; k++) begin
         @(negedge clock);
         if (k == 0) begin
            start = 1'b1; base_addr = 9'(base); length = 10'(len);
         end else if (rmode == 2 && k == 3) begin
            start = 1'b1; base_addr = 9'd100; length = 10'd3;
         end else begin
            start = 1'b0;
         end
         out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         if (mem_en) begin addr_log.push_back(int'(mem_addr)); en_cnt++; end
         if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) viol++;
         if (busy) busy_seen = 1;
         if (out_valid) valid_seen = 1;
         if (k >= 1 && len > 0 && !busy && !done) busy_drop++;
         if (out_valid && out_ready) begin
            beat_d.push_back(out_data); beat_l.push_back(out_last); hs_cyc.push_back(k);
         end
         if (done) begin done_cyc = k; break; end
         pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, mem_en, mem_addr, out_valid, out_data, out_last} !== '0) begin
         errors++; $display("FAIL reset_outputs: got busy=%b done=%b en=%b addr=%0d valid=%b data=%0h last=%b, want all 0",
                            busy, done, mem_en, mem_addr, out_valid, out_data, out_last);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_idle: busy=%b valid=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_basic();
      do_xfer(0, 4, 0, 40);
      checks++;
      if (beat_d.size() != 4 || beat_d[0] !== 32'd0 || beat_d[1] !== 32'd3 ||
          beat_d[2] !== 32'd6 || beat_d[3] !== 32'd9) begin
         errors++; $display("FAIL basic_data: got %0d beats %p, want 0 3 6 9", beat_d.size(), beat_d);
      end
      checks++;
      if (beat_l.size() != 4 || {beat_l[0], beat_l[1], beat_l[2], beat_l[3]} !== 4'b0001) begin
         errors++; $display("FAIL basic_last: got %p, want last only on beat 4", beat_l);
      end
      checks++;
      if (hs_cyc.size() != 4 || done_cyc != hs_cyc[3] + 1) begin
         errors++; $display("FAIL basic_done: done at cycle %0d, want one after last handshake", done_cyc);
      end
      checks++;
      if (busy_drop != 0 || !busy_seen) begin
         errors++; $display("FAIL basic_busy: drops=%0d seen=%b, want 0 1", busy_drop, busy_seen);
      end
      @(negedge clock); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_after: busy=%b done=%b valid=%b want 0 0 0", busy, done, out_valid);
      end
   endtask

   task automatic test_wrap();
      do_xfer(510, 4, 0, 40);
      checks++;
      if (addr_log.size() != 4 || addr_log[0] != 510 || addr_log[1] != 511 ||
          addr_log[2] != 0 || addr_log[3] != 1) begin
         errors++; $display("FAIL wrap_addr: got %p, want 510 511 0 1", addr_log);
      end
      checks++;
      if (beat_d.size() != 4 || beat_d[0] !== 32'd1530 || beat_d[1] !== 32'd1533 ||
          beat_d[2] !== 32'd0 || beat_d[3] !== 32'd3) begin
         errors++; $display("FAIL wrap_data: got %p, want 1530 1533 0 3", beat_d);
      end
   endtask

   task automatic test_backpressure(input int rmode, input string name);
      int bad;
      do_xfer(40, 8, rmode, 300);
      bad = 0;
      for (int i = 0; i < beat_d.size(); i++) begin
         if (beat_d[i] !== 32'((40 + i) * 3)) bad++;
         if (beat_l[i] !== (i == 7)) bad++;
      end
      checks++;
      if (beat_d.size() != 8 || bad != 0 || done_cyc < 0) begin
         errors++; $display("FAIL %s_beats: got %0d beats, %0d bad, done_cyc=%0d, want 8 0 >=0",
                            name, beat_d.size(), bad, done_cyc);
      end
      checks++;
      if (viol != 0 || en_cnt != 8) begin
         errors++; $display("FAIL %s_protocol: stall violations=%0d reads=%0d, want 0 8", name, viol, en_cnt);
      end
   endtask

   task automatic test_zero_len();
      do_xfer(12, 0, 0, 10);
      checks++;
      if (done_cyc != 1 || en_cnt != 0 || valid_seen || busy_seen) begin
         errors++; $display("FAIL zero_len: done_cyc=%0d reads=%0d valid=%b busy=%b, want 1 0 0 0",
                            done_cyc, en_cnt, valid_seen, busy_seen);
      end
   endtask

   task automatic test_reset_mid();
      int stale;
      @(negedge clock); start = 1'b1; base_addr = 9'd20; length = 10'd8; out_ready = 1'b0;
      @(negedge clock); start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, mem_en, mem_addr, out_valid, out_data, out_last} !== '0) begin
         errors++; $display("FAIL midreset_outputs: busy=%b en=%b addr=%0d valid=%b data=%0h, want all 0",
                            busy, mem_en, mem_addr, out_valid, out_data);
      end
      @(negedge clock); reset = 1'b0; out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 4; i++) begin
         #1; if (out_valid || mem_en || busy) stale++;
         @(negedge clock);
      end
      checks++;
      if (stale != 0) begin
         errors++; $display("FAIL midreset_stale: %0d cycles with activity after release, want 0", stale);
      end
      do_xfer(5, 3, 0, 40);
      checks++;
      if (beat_d.size() != 3 || beat_d[0] !== 32'd15 || beat_d[1] !== 32'd18 || beat_d[2] !== 32'd21) begin
         errors++; $display("FAIL midreset_new: got %p, want 15 18 21", beat_d);
      end
   endtask

   task automatic test_full_depth();
      int bad, nlast;
      do_xfer(300, 512, 0, 700);
      bad = 0; nlast = 0;
      for (int i = 0; i < beat_d.size(); i++) begin
         if (beat_d[i] !== 32'(((300 + i) % 512) * 3)) bad++;
         if (beat_l[i]) nlast++;
      end
      checks++;
      if (beat_d.size() != 512 || bad != 0) begin
         errors++; $display("FAIL full_data: got %0d beats, %0d bad, want 512 0", beat_d.size(), bad);
      end
      checks++;
      if (nlast != 1 || beat_l.size() != 512 || !beat_l[511]) begin
         errors++; $display("FAIL full_last: %0d lasts, want exactly one on beat 512", nlast);
      end
      checks++;
      if (hs_cyc.size() != 512 || hs_cyc[511] - hs_cyc[0] != 511) begin
         errors++; $display("FAIL full_throughput: span=%0d beats=%0d, want 511 512",
                            (hs_cyc.size() == 512) ? hs_cyc[511] - hs_cyc[0] : -1, hs_cyc.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'(i * 3);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure(1, "random_ready");
      test_zero_len();
      test_backpressure(2, "restart_ignored");
      test_reset_mid();
      test_full_depth();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
